// File: rtl/timer_arb_pkg.sv
// Shared types and arbitration helper for timer_arbiter.
// pick_winner scans requests starting at 'start' and wraps modulo n_req.
package timer_arb_pkg;

    localparam int CW_DEFAULT = 16;
    localparam int MAX_REQ    = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } arb_state_e;

    function automatic logic [2:0] pick_winner(
        input logic [MAX_REQ-1:0] req,
        input logic [2:0]         start,
        input int                 n_req
    );
        logic [2:0] win;
        logic       found;
        int         idx;
        win   = 3'd0;
        found = 1'b0;
        for (int i = 0; i < MAX_REQ; i++) begin
            idx = int'(start) + i;
            if (idx >= n_req) idx = idx - n_req;
            if (i < n_req && !found && req[idx[2:0]]) begin
                win   = idx[2:0];
                found = 1'b1;
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/timer.sv
// Shared 16-bit down-counter core: load captures a count, busy while nonzero.
module timer
    import timer_arb_pkg::*;
#(
    parameter int CW = CW_DEFAULT
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load_i,
    input  logic [CW-1:0] cycles_i,
    output logic          busy_o
);

    logic [CW-1:0] count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= cycles_i;
        end else if (count_q != '0) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign busy_o = (count_q != '0);

endmodule

// File: rtl/timer_arbiter.sv
// Arbitrates one timer core among N_REQ requesters; pulses done[owner] on expiry.
// Define TIMER_ARB_RR_EN for round-robin arbitration (default: fixed priority, index 0 highest).
module timer_arbiter
    import timer_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int CW    = CW_DEFAULT
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [N_REQ-1:0]    req_i,
    input  logic [N_REQ*CW-1:0] cycles_i,
    output logic [N_REQ-1:0]    grant_o,
    output logic [N_REQ-1:0]    done_o,
    output logic                busy_o,
    output logic [2:0]          active_id_o
);

    localparam logic [N_REQ-1:0] ONE_HOT0 = {{(N_REQ-1){1'b0}}, 1'b1};

    arb_state_e       state_q, state_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic [2:0]       active_id_q, active_id_d;
    logic [7:0]       req_ext;
    logic [2:0]       start;
    logic [2:0]       winner;
    logic [CW-1:0]    sel_cycles;
    logic             abort;
    logic             core_reset;
    logic             core_load;
    logic             core_busy;

    assign req_ext    = 8'(req_i);
    assign winner     = pick_winner(req_ext, start, N_REQ);
    assign abort      = ((state_q == LOAD) || (state_q == RUN)) && !req_ext[active_id_q];
    assign core_reset = reset | abort;

    always_comb begin
        sel_cycles = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (active_id_q == 3'(i)) sel_cycles = cycles_i[i*CW +: CW];
        end
    end

`ifdef TIMER_ARB_RR_EN
    // Pointer holds where the next search starts; only a completed service moves it.
    logic [2:0] ptr_q, ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (state_q == DONE) begin
            ptr_d = (active_id_q == 3'(N_REQ-1)) ? 3'd0 : active_id_q + 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) ptr_q <= 3'd0;
        else       ptr_q <= ptr_d;
    end

    assign start = ptr_q;
`else
    assign start = 3'd0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            active_id_q <= 3'd0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            active_id_q <= active_id_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        active_id_d = active_id_q;
        case (state_q)
            IDLE: begin
                if (|req_i) begin
                    state_d     = LOAD;
                    active_id_d = winner;
                    grant_d     = ONE_HOT0 << winner;
                end
            end
            LOAD: begin
                if (abort) begin
                    state_d = IDLE;
                    grant_d = '0;
                end else if (sel_cycles == '0) begin
                    state_d = DONE;
                end else begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                    grant_d = '0;
                end else if (!core_busy) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
                grant_d = '0;
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_comb begin
        core_load = (state_q == LOAD) && (sel_cycles != '0);
        done_o    = (state_q == DONE) ? (ONE_HOT0 << active_id_q) : '0;
        busy_o    = (state_q != IDLE);
    end

    assign grant_o     = grant_q;
    assign active_id_o = active_id_q;

    timer #(.CW(CW)) u_core (
        .clk      (clk),
        .reset    (core_reset),
        .load_i   (core_load),
        .cycles_i (sel_cycles),
        .busy_o   (core_busy)
    );

    a_grant_onehot: assert property (@(posedge clk) disable iff (reset) $onehot0(grant_q));
    a_grant_state:  assert property (@(posedge clk) disable iff (reset) (grant_q != '0) == (state_q != IDLE));
    a_done_state:   assert property (@(posedge clk) disable iff (reset) (done_o != '0) |-> (state_q == DONE));
    a_load_state:   assert property (@(posedge clk) disable iff (reset) core_load |-> (state_q == LOAD));
    c_abort:        cover property (@(posedge clk) disable iff (reset) abort);

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_cov
        c_done: cover property (@(posedge clk) disable iff (reset) done_o[gi]);
    end

endmodule
